tiny_alu_arbiter: RTL and testbench
===================================

# tiny_alu_arbiter

Round-robin scheduler that shares one tiny ALU between `NUM_REQ` requesters. It accepts one operation at a time with a valid/ready handshake and drives the ALU's start, opcode and operand inputs. It waits for the ALU's done, then returns the result to the requester that issued the operation. It sits between the requester blocks and the ALU bus interface, and is the only driver of the ALU inputs.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `INPUT_DATA_BITS`, 8, operand width; result width is `2*INPUT_DATA_BITS`.
- `TIMEOUT_CYCLES`, 4, maximum WAIT cycles before an operation is aborted (≥2).

Ports:
- `clk_i` in 1: clock. One clock domain only.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `req_valid_i` in NUM_REQ: per-requester request valid.
- `req_ready_o` out NUM_REQ: per-requester accept; at most one bit high at a time.
- `req_opcode_i` in NUM_REQ*3: packed opcodes; requester k uses bits [3k+2:3k].
- `req_a_i`, `req_b_i` in NUM_REQ*INPUT_DATA_BITS: packed operands.
- `rsp_valid_o` out NUM_REQ: one-cycle response pulse to the owning requester.
- `rsp_result_o` out 2*INPUT_DATA_BITS: result, shared by all requesters, qualified by `rsp_valid_o`.
- `rsp_error_o` out 1: qualified by `rsp_valid_o`; 1 means illegal opcode or timeout.
- `alu_start_o`, `alu_opcode_o` (3), `alu_a_o`, `alu_b_o` (INPUT_DATA_BITS): ALU inputs.
- `alu_result_i` (2*INPUT_DATA_BITS), `alu_done_i` (1): ALU outputs, registered inside the ALU.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- Opcodes: NOP=0, ADD=1, AND=2, XOR=3, MUL=4. Values 5–7 are illegal.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The arbiter picks the winner among the set `req_valid_i` bits, round-robin, searching from `last_grant+1` upward with wrap-around.
  - `req_ready_o[winner]=1` is combinational in the same cycle.
  - On the handshake it latches the opcode, operands and winner index into `owner`, and updates `last_grant` to `owner`.
  - Legal opcode goes to ISSUE. Illegal opcode goes directly to RESP with error set; the ALU is not started.
- ISSUE:
  - `alu_start_o=1` for exactly one cycle, with the latched opcode and operands. Then go to WAIT.
- WAIT:
  - A counter counts cycles in WAIT.
  - If `alu_done_i=1`, capture `alu_result_i`, clear error, go to RESP.
  - If `TIMEOUT_CYCLES` WAIT cycles pass with no done, set result 0 and error 1, go to RESP.
  - If done and the final timeout cycle coincide, done wins.
- RESP:
  - `rsp_valid_o[owner]=1`, `rsp_result_o` and `rsp_error_o` are driven from registers. Then go to IDLE.
  - No request is accepted in RESP.
- The arbiter does not look at `alu_done_i` outside WAIT.
- Requesters must hold their valid, opcode and operands stable until ready. A request dropped before ready is simply not served.
- ALU outputs are zero whenever `alu_start_o=0`: opcode 0, operands 0.

## Timing
- Reset state: IDLE, `last_grant=NUM_REQ-1` (requester 0 has highest priority first), and every output 0.
- Reset mid-operation aborts the operation. No response is issued, and the pending request is lost.
- Legal operation, cycle by cycle:
  - Handshake at cycle T.
  - `alu_start_o` at T+1.
  - `alu_done_i` expected at T+2.
  - `rsp_valid_o` at T+3.
  - Next handshake no earlier than T+4. Peak throughput is one operation per 4 cycles.
- Illegal opcode: handshake at T, response at T+1.
- Timeout: response at T+2+TIMEOUT_CYCLES.
- Width rules:
  - ADD result is zero-extended and includes the carry (255+255=510).
  - MUL produces the full product (255*255=65025).
  - AND/XOR results are zero-extended; NOP returns 0.

## Structure
- Add to the shared tiny ALU package:
  - 3-bit opcode enum `tiny_alu_op_t` with values NOP..MUL.
  - State enum `tiny_alu_arb_state_t`.
  - Constant `TINY_ALU_OP_MAX = MUL_OP`.
- Sub-module `tiny_alu_rr_grant`:
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; reusable by other shared-resource blocks.
- The top level holds the FSM, operand/owner latches, the timeout counter, the result register, and the ALU drive logic.

## Test plan
- Single request: req0 ADD a=200, b=100 → `alu_start_o` one cycle after handshake; `rsp_valid_o[0]` at T+3 with result 300, error 0.
- Contention: req0–3 all valid continuously, each with MUL 15×17 → grants in order 0,1,2,3,0; every response returns 255 to the matching requester bit.
- Illegal opcode: req2 opcode 6 → no `alu_start_o`; `rsp_valid_o[2]` at T+1 with error 1, result 0.
- Timeout: ALU model holds `alu_done_i=0`, req1 XOR → `rsp_valid_o[1]` at T+2+TIMEOUT_CYCLES with error 1, result 0; next request is served normally.
- Reset: assert `reset_n_i` low during WAIT → all outputs 0 immediately; no `rsp_valid_o`; after release, req3 and req0 both valid → req0 is granted first.

Source files
------------

// File: rtl/tiny_alu_pkg.sv
// Shared definitions for the tiny ALU and the blocks that share it:
// opcode encoding, arbiter state encoding and opcode legality.
package tiny_alu_pkg;

    typedef enum logic [2:0] {
        NOP_OP = 3'd0,
        ADD_OP = 3'd1,
        AND_OP = 3'd2,
        XOR_OP = 3'd3,
        MUL_OP = 3'd4
    } tiny_alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } tiny_alu_arb_state_t;

    localparam tiny_alu_op_t TINY_ALU_OP_MAX = MUL_OP;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= TINY_ALU_OP_MAX;
    endfunction

endpackage

// File: rtl/tiny_alu_rr_grant.sv
// Combinational round-robin picker: first set request strictly after
// last_grant_i, wrapping around. Reusable by any shared-resource arbiter.
module tiny_alu_rr_grant #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    int   w_cand;
    logic w_found;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant_o     = '0;
        grant_idx_o = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = int'(last_grant_i) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            if (!w_found && req_i[w_cand]) begin
                w_found         = 1'b1;
                grant_o[w_cand] = 1'b1;
                grant_idx_o     = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/tiny_alu_arbiter.sv
// Round-robin scheduler sharing one tiny ALU between NUM_REQ requesters:
// accept, issue, wait for done (with timeout), respond to the owner.
module tiny_alu_arbiter
    import tiny_alu_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int INPUT_DATA_BITS = 8,
    parameter int TIMEOUT_CYCLES  = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic [NUM_REQ*3-1:0]           req_opcode_i,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_a_i,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0] req_b_i,
    output logic [NUM_REQ-1:0]             rsp_valid_o,
    output logic [2*INPUT_DATA_BITS-1:0]   rsp_result_o,
    output logic                           rsp_error_o,
    output logic                           alu_start_o,
    output logic [2:0]                     alu_opcode_o,
    output logic [INPUT_DATA_BITS-1:0]     alu_a_o,
    output logic [INPUT_DATA_BITS-1:0]     alu_b_o,
    input  logic [2*INPUT_DATA_BITS-1:0]   alu_result_i,
    input  logic                           alu_done_i,
    output logic                           busy_o
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RES_W = 2 * INPUT_DATA_BITS;
    localparam int DW    = INPUT_DATA_BITS;

    tiny_alu_arb_state_t  r_state;
    logic [IDX_W-1:0]     r_owner;
    logic [IDX_W-1:0]     r_last_grant;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [RES_W-1:0]     r_result;
    logic                 r_error;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic                 r_alu_start;
    logic [2:0]           r_alu_opcode;
    logic [DW-1:0]        r_alu_a;
    logic [DW-1:0]        r_alu_b;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_accept;
    logic [2:0]           w_sel_op;
    logic [DW-1:0]        w_sel_a;
    logic [DW-1:0]        w_sel_b;

    tiny_alu_rr_grant #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_grant (
        .req_i       (req_valid_i),
        .last_grant_i(r_last_grant),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx)
    );

    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign w_accept    = (r_state == ST_IDLE) && reset_n_i && (|req_valid_i);
    assign req_ready_o = w_accept ? w_grant : '0;

    assign w_sel_op = req_opcode_i[3*w_grant_idx +: 3];
    assign w_sel_a  = req_a_i[DW*w_grant_idx +: DW];
    assign w_sel_b  = req_b_i[DW*w_grant_idx +: DW];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_wait_cnt   <= '0;
            r_result     <= '0;
            r_error      <= 1'b0;
            r_rsp_valid  <= '0;
            r_alu_start  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
        end else begin
            // NOTE: non-blocking assignments; the defaults below are overridden later in the same block.
            r_alu_start  <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= '0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_owner      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        if (op_is_legal(w_sel_op)) begin
                            r_alu_start  <= 1'b1;
                            r_alu_opcode <= w_sel_op;
                            r_alu_a      <= w_sel_a;
                            r_alu_b      <= w_sel_b;
                            r_state      <= ST_ISSUE;
                        end else begin
                            r_result    <= '0;
                            r_error     <= 1'b1;
                            r_rsp_valid <= NUM_REQ'(1) << w_grant_idx;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done is tested first so it wins over the last timeout cycle.
                    if (alu_done_i) begin
                        r_result    <= alu_result_i;
                        r_error     <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= ST_RESP;
                    end else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_result    <= '0;
                        r_error     <= 1'b1;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_result <= '0;
                    r_error  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_result_o = r_result;
    assign rsp_error_o  = r_error;
    assign alu_start_o  = r_alu_start;
    assign alu_opcode_o = r_alu_opcode;
    assign alu_a_o      = r_alu_a;
    assign alu_b_o      = r_alu_b;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tiny_alu_arbiter.sv
// Self-checking bench: a configurable-latency ALU model, a transaction-level
// schedule model compared every cycle, and directed scenarios with literal checks.
module tb_tiny_alu_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 4;

    logic            clk_i = 1'b0;
    logic            reset_n_i;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*3-1:0]  req_opcode_i;
    logic [N*W-1:0]  req_a_i;
    logic [N*W-1:0]  req_b_i;
    logic [N-1:0]    rsp_valid_o;
    logic [2*W-1:0]  rsp_result_o;
    logic            rsp_error_o;
    logic            alu_start_o;
    logic [2:0]      alu_opcode_o;
    logic [W-1:0]    alu_a_o;
    logic [W-1:0]    alu_b_o;
    logic [2*W-1:0]  alu_result_i;
    logic            alu_done_i;
    logic            busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int alu_delay = 1;  // 0 = ALU never answers
    int alu_cnt;
    logic [2*W-1:0] alu_hold;

    tiny_alu_arbiter #(.NUM_REQ(N), .INPUT_DATA_BITS(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opcode_i(req_opcode_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
        .alu_start_o(alu_start_o), .alu_opcode_o(alu_opcode_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_done_i(alu_done_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] f_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned x, y;
        x = a;
        y = b;
        case (op)
            3'd1:    return 16'(x + y);
            3'd2:    return 16'(x & y);
            3'd3:    return 16'(x ^ y);
            3'd4:    return 16'(x * y);
            default: return 16'd0;
        endcase
    endfunction

    // ALU model: result registered, done appears alu_delay cycles after start.
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            alu_done_i   <= 1'b0;
            alu_result_i <= '0;
            alu_cnt      <= 0;
            alu_hold     <= '0;
        end else begin
            alu_done_i   <= 1'b0;
            alu_result_i <= '0;
            if (alu_start_o) begin
                if (alu_delay == 1) begin
                    alu_done_i   <= 1'b1;
                    alu_result_i <= f_alu(alu_opcode_o, alu_a_o, alu_b_o);
                    alu_cnt      <= 0;
                end else if (alu_delay >= 2) begin
                    alu_cnt  <= alu_delay - 1;
                    alu_hold <= f_alu(alu_opcode_o, alu_a_o, alu_b_o);
                end else begin
                    alu_cnt <= 0;
                end
            end else if (alu_cnt != 0) begin
                alu_cnt <= alu_cnt - 1;
                if (alu_cnt == 1) begin
                    alu_done_i   <= 1'b1;
                    alu_result_i <= alu_hold;
                end
            end
        end
    end

    // Schedule model: each accepted operation fixes the absolute cycles of its
    // ALU start and its response; the arbiter is free again after the response.
    int          m_last, m_free_at, m_start_cyc, m_rsp_cyc, m_owner;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_res;
    logic        m_err;

    always @(negedge clk_i) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        int  win;
        bit  idle;
        if (!reset_n_i) begin
            m_last = N - 1; m_free_at = 0; m_start_cyc = -1; m_rsp_cyc = -1;
            check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_result_o, rsp_error_o,
                  alu_start_o, alu_opcode_o, alu_a_o, alu_b_o, busy_o}, 64'd0);
        end else begin
            idle    = (cyc >= m_free_at);
            e_ready = '0;
            win     = -1;
            if (idle) begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (m_last + i) % N;
                    if (win < 0 && req_valid_i[k]) win = k;
                end
            end
            if (win >= 0) e_ready[win] = 1'b1;
            check("ready", req_ready_o, e_ready);
            check("busy", busy_o, !idle);
            check("alu_start", alu_start_o, cyc == m_start_cyc);
            check("alu_bus", {alu_opcode_o, alu_a_o, alu_b_o},
                  (cyc == m_start_cyc) ? {m_op, m_a, m_b} : 19'd0);
            e_rsp = (cyc == m_rsp_cyc) ? (N'(1) << m_owner) : '0;
            check("rsp_valid", rsp_valid_o, e_rsp);
            if (cyc == m_rsp_cyc) check("rsp_data", {rsp_error_o, rsp_result_o}, {m_err, m_res});
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_op    = req_opcode_i[win*3 +: 3];
                m_a     = req_a_i[win*W +: W];
                m_b     = req_b_i[win*W +: W];
                if (m_op > 3'd4) begin
                    m_start_cyc = -1;
                    m_rsp_cyc   = cyc + 1;
                    m_res = 0; m_err = 1'b1;
                end else begin
                    m_start_cyc = cyc + 1;
                    if (alu_delay >= 1 && alu_delay <= TO) begin
                        m_rsp_cyc = cyc + 2 + alu_delay;
                        m_res = f_alu(m_op, m_a, m_b); m_err = 1'b0;
                    end else begin
                        m_rsp_cyc = cyc + 2 + TO;
                        m_res = 0; m_err = 1'b1;
                    end
                end
                m_free_at = m_rsp_cyc + 1;
            end
        end
    end

    task automatic set_req(input int k, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_opcode_i[k*3 +: 3] = op;
        req_a_i[k*W +: W]      = a;
        req_b_i[k*W +: W]      = b;
        req_valid_i[k]         = 1'b1;
    endtask

    task automatic wait_hs(input int k, output int th);
        bit got = 0;
        th = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (req_ready_o[k] && req_valid_i[k]) begin got = 1; th = cyc; break; end
        end
        check($sformatf("handshake_seen_req%0d", k), got, 1);
        @(posedge clk_i); #1;
        req_valid_i[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int tr, output logic [15:0] res, output logic err);
        bit got = 0;
        tr = -1; res = 'x; err = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o[k]) begin got = 1; tr = cyc; res = rsp_result_o; err = rsp_error_o; break; end
        end
        check($sformatf("response_seen_req%0d", k), got, 1);
    endtask

    task automatic do_op(input string name, input int k, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input int lat, input logic [15:0] res_exp, input logic err_exp);
        int th, tr;
        logic [15:0] res;
        logic err;
        set_req(k, op, a, b);
        wait_hs(k, th);
        wait_rsp(k, tr, res, err);
        check({name, "_latency"}, tr - th, lat);
        check({name, "_result"}, res, res_exp);
        check({name, "_error"}, err, err_exp);
        @(posedge clk_i); #1;
    endtask

    initial begin
        int q_grants[$];
        int th, tr;
        logic [15:0] res;
        logic err;
        reset_n_i = 1'b0;
        req_valid_i = '0; req_opcode_i = '0; req_a_i = '0; req_b_i = '0;
        repeat (3) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        do_op("add_200_100", 0, 3'd1, 8'd200, 8'd100, 3, 16'd300, 1'b0);
        do_op("add_carry",   1, 3'd1, 8'd255, 8'd255, 3, 16'd510, 1'b0);
        do_op("and",         2, 3'd2, 8'hF0, 8'h3C,  3, 16'h0030, 1'b0);
        do_op("nop",         0, 3'd0, 8'd5,  8'd6,   3, 16'd0, 1'b0);
        do_op("mul_full",    3, 3'd4, 8'd255, 8'd255, 3, 16'd65025, 1'b0);

        // Contention: all four hold MUL 15x17; last grant was requester 3.
        for (int k = 0; k < N; k++) set_req(k, 3'd4, 8'd15, 8'd17);
        for (int i = 0; i < 100 && q_grants.size() < 5; i++) begin
            @(negedge clk_i);
            if (|rsp_valid_o) check("contention_result", rsp_result_o, 16'd255);
            if (|(req_ready_o & req_valid_i)) begin
                for (int k = 0; k < N; k++) if (req_ready_o[k]) q_grants.push_back(k);
            end
        end
        @(posedge clk_i); #1;
        req_valid_i = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            if (|rsp_valid_o) check("contention_result", rsp_result_o, 16'd255);
        end
        check("contention_grant_count", q_grants.size(), 5);
        for (int i = 0; i < q_grants.size(); i++)
            check($sformatf("contention_grant_%0d", i), q_grants[i], i % N);
        @(posedge clk_i); #1;

        do_op("illegal_op6", 2, 3'd6, 8'd1, 8'd2, 1, 16'd0, 1'b1);

        alu_delay = 0;
        do_op("timeout_xor", 1, 3'd3, 8'hAA, 8'h55, 2 + TO, 16'd0, 1'b1);
        alu_delay = 1;
        do_op("after_timeout", 1, 3'd3, 8'hAA, 8'h55, 3, 16'h00FF, 1'b0);

        alu_delay = TO;
        do_op("done_on_last_wait", 0, 3'd1, 8'd1, 8'd2, 2 + TO, 16'd3, 1'b0);
        alu_delay = TO + 1;
        do_op("done_one_too_late", 0, 3'd1, 8'd1, 8'd2, 2 + TO, 16'd0, 1'b1);
        alu_delay = 1;
        do_op("after_late_done", 3, 3'd1, 8'd10, 8'd20, 3, 16'd30, 1'b0);

        // Reset while the arbiter sits in WAIT with a silent ALU.
        alu_delay = 0;
        set_req(2, 3'd1, 8'd9, 8'd9);
        wait_hs(2, th);
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b0;
        #1 check("reset_immediate", {rsp_valid_o, alu_start_o, busy_o, rsp_error_o, alu_opcode_o}, 64'd0);
        set_req(3, 3'd1, 8'd7, 8'd8);
        set_req(0, 3'd1, 8'd1, 8'd1);
        alu_delay = 1;
        repeat (2) @(posedge clk_i);
        #1 reset_n_i = 1'b1;
        th = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (|(req_ready_o & req_valid_i)) begin th = cyc; break; end
        end
        check("post_reset_first_grant", req_ready_o, 4'b0001);
        @(posedge clk_i); #1;
        req_valid_i[0] = 1'b0;
        wait_rsp(0, tr, res, err);
        check("post_reset_req0_result", res, 16'd2);
        check("post_reset_req0_latency", tr - th, 3);
        wait_hs(3, th);
        wait_rsp(3, tr, res, err);
        check("post_reset_req3_result", res, 16'd15);
        repeat (3) @(posedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
